// File: rtl/tpu_host_ctrl_if.sv
// Host-side handshake bundle for the TPU host controller: job command,
// operand load stream and result stream.
interface tpu_host_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_K;
  logic [7:0]  cmd_M;
  logic [7:0]  cmd_N;

  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  // host / testbench side
  modport master (
    output cmd_valid, cmd_K, cmd_M, cmd_N, ld_valid, ld_data, out_ready,
    input  cmd_ready, ld_ready, out_valid, out_data, out_last
  );

  // controller side
  modport slave (
    input  cmd_valid, cmd_K, cmd_M, cmd_N, ld_valid, ld_data, out_ready,
    output cmd_ready, ld_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/tpu_host_ctrl.sv
// TPU host controller: accepts a K/M/N job, streams A then B operands into
// the TPU buffers, launches the TPU, waits for it to finish and drains the
// C buffer to the host as 32-bit words (MSW of each 128-bit row first).
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | cmd_ready high, waiting for a job command
// LOAD_A    | accepting NA load beats into the A buffer
// LOAD_B    | accepting NB load beats into the B buffer
// LAUNCH    | one-cycle tpu_in_valid pulse
// WAIT_HI   | waiting for tpu_busy to rise (gives up after 16 cycles)
// WAIT_LO   | waiting for tpu_busy to fall
// DRAIN_RD  | present C_index, then capture C_data_out one cycle later
// DRAIN_OUT | emit the captured row as 4 words on the result stream
// DONE      | one-cycle done pulse
module tpu_host_ctrl #(
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  tpu_host_ctrl_if.slave   bus,
  output logic             A_wr_en,
  output logic [IDX_W-1:0] A_index,
  output logic [31:0]      A_data_in,
  output logic             B_wr_en,
  output logic [IDX_W-1:0] B_index,
  output logic [31:0]      B_data_in,
  output logic [IDX_W-1:0] C_index,
  input  logic [127:0]     C_data_out,
  output logic             tpu_in_valid,
  output logic [7:0]       tpu_K,
  output logic [7:0]       tpu_M,
  output logic [7:0]       tpu_N,
  input  logic             tpu_busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [3:0] {
    IDLE, LOAD_A, LOAD_B, LAUNCH, WAIT_HI, WAIT_LO, DRAIN_RD, DRAIN_OUT, DONE
  } state_t;

  state_t       state;
  logic [15:0]  idx;
  logic [15:0]  na;
  logic [15:0]  nb;
  logic [15:0]  nc;
  logic [15:0]  row;
  logic [3:0]   tmo;
  logic [1:0]   word;
  logic         rd_phase;
  logic [127:0] hold;

  logic [15:0]  m_blk;
  logic [15:0]  n_blk;
  logic         beat;
  logic         dim_zero;

  // Job sizes are derived straight from the command so they can be latched on acceptance.
  assign m_blk    = ({8'd0, bus.cmd_M} + 16'd3) >> 2;
  assign n_blk    = ({8'd0, bus.cmd_N} + 16'd3) >> 2;
  assign dim_zero = (bus.cmd_K == 8'd0) || (bus.cmd_M == 8'd0) || (bus.cmd_N == 8'd0);
  assign beat     = bus.ld_valid && bus.ld_ready;

  // Buffer writes follow the accepted beat in the same cycle.
  assign A_wr_en   = beat && (state == LOAD_A);
  assign B_wr_en   = beat && (state == LOAD_B);
  assign A_index   = A_wr_en ? IDX_W'(idx) : '0;
  assign B_index   = B_wr_en ? IDX_W'(idx) : '0;
  assign A_data_in = A_wr_en ? bus.ld_data : '0;
  assign B_data_in = B_wr_en ? bus.ld_data : '0;
  assign C_index   = IDX_W'(row);

  assign bus.out_last = bus.out_valid && (word == 2'd3) && (row == nc - 16'd1);

  // Select the current result word from the hold register, most significant first.
  always_comb begin
    bus.out_data = '0;
    if (bus.out_valid) begin
      case (word)
        2'd0:    bus.out_data = hold[127:96];
        2'd1:    bus.out_data = hold[95:64];
        2'd2:    bus.out_data = hold[63:32];
        default: bus.out_data = hold[31:0];
      endcase
    end
  end

  // Job sequencer with registered handshake and pulse outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      na            <= '0;
      nb            <= '0;
      nc            <= '0;
      row           <= '0;
      tmo           <= '0;
      word          <= '0;
      rd_phase      <= 1'b0;
      hold          <= '0;
      tpu_K         <= '0;
      tpu_M         <= '0;
      tpu_N         <= '0;
      tpu_in_valid  <= 1'b0;
      bus.cmd_ready <= 1'b0;
      bus.ld_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          bus.cmd_ready <= 1'b1;
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_ready <= 1'b0;
            if (dim_zero) begin
              err <= 1'b1;
            end else begin
              tpu_K        <= bus.cmd_K;
              tpu_M        <= bus.cmd_M;
              tpu_N        <= bus.cmd_N;
              na           <= {8'd0, bus.cmd_K} * m_blk;
              nb           <= {8'd0, bus.cmd_K} * n_blk;
              nc           <= {8'd0, bus.cmd_M} * n_blk;
              idx          <= '0;
              bus.ld_ready <= 1'b1;
              state        <= LOAD_A;
            end
          end
        end
        LOAD_A: begin
          if (beat) begin
            if (idx == na - 16'd1) begin
              idx   <= '0;
              state <= LOAD_B;
            end else begin
              idx <= idx + 16'd1;
            end
          end
        end
        LOAD_B: begin
          if (beat) begin
            if (idx == nb - 16'd1) begin
              idx          <= '0;
              bus.ld_ready <= 1'b0;
              tpu_in_valid <= 1'b1;
              state        <= LAUNCH;
            end else begin
              idx <= idx + 16'd1;
            end
          end
        end
        LAUNCH: begin
          // 14 down to 0 spans the 15 WAIT_HI cycles, so WAIT_LO lands 16 cycles after LAUNCH.
          tpu_in_valid <= 1'b0;
          tmo          <= 4'd14;
          state        <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tpu_busy || (tmo == 4'd0)) begin
            state <= WAIT_LO;
          end else begin
            tmo <= tmo - 4'd1;
          end
        end
        WAIT_LO: begin
          if (!tpu_busy) begin
            row      <= '0;
            rd_phase <= 1'b0;
            state    <= DRAIN_RD;
          end
        end
        DRAIN_RD: begin
          // First cycle presents C_index; read data is valid on the second.
          if (!rd_phase) begin
            rd_phase <= 1'b1;
          end else begin
            rd_phase      <= 1'b0;
            hold          <= C_data_out;
            word          <= '0;
            bus.out_valid <= 1'b1;
            state         <= DRAIN_OUT;
          end
        end
        DRAIN_OUT: begin
          if (bus.out_ready) begin
            if (word == 2'd3) begin
              word          <= '0;
              bus.out_valid <= 1'b0;
              if (row == nc - 16'd1) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                row   <= row + 16'd1;
                state <= DRAIN_RD;
              end
            end else begin
              word <= word + 2'd1;
            end
          end
        end
        DONE: begin
          done          <= 1'b0;
          bus.cmd_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_host_ctrl.sv
// Directed bench for tpu_host_ctrl: normal jobs, stalled drain, rejected
// job, busy timeout and mid-job resets.
module tb_tpu_host_ctrl;
  localparam int IDX_W = 16;

  logic              clk;
  logic              rst_n;
  logic              A_wr_en, B_wr_en;
  logic [IDX_W-1:0]  A_index, B_index, C_index;
  logic [31:0]       A_data_in, B_data_in;
  logic [127:0]      C_data_out;
  logic              tpu_in_valid;
  logic [7:0]        tpu_K, tpu_M, tpu_N;
  logic              tpu_busy;
  logic              done, err;

  tpu_host_ctrl_if bus ();

  tpu_host_ctrl #(.IDX_W(IDX_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .A_wr_en      (A_wr_en),
    .A_index      (A_index),
    .A_data_in    (A_data_in),
    .B_wr_en      (B_wr_en),
    .B_index      (B_index),
    .B_data_in    (B_data_in),
    .C_index      (C_index),
    .C_data_out   (C_data_out),
    .tpu_in_valid (tpu_in_valid),
    .tpu_K        (tpu_K),
    .tpu_M        (tpu_M),
    .tpu_N        (tpu_N),
    .tpu_busy     (tpu_busy),
    .done         (done),
    .err          (err)
  );

  int n_chk;
  int n_err;
  int cyc;
  bit rand_mode;

  logic [47:0]  a_q[$];
  logic [47:0]  b_q[$];
  logic [31:0]  out_q[$];
  logic         last_q[$];
  int           rise_q[$];
  int           launch_cnt, launch_cyc, done_cnt, err_cnt;
  int           stall_bad, stall_seen;
  logic [23:0]  launch_kmn;
  logic         prev_ov, prev_stall;
  logic [31:0]  prev_data;
  logic [127:0] c_mem [0:7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle counter for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  // C buffer model: synchronous read, data one cycle after the address
  always @(posedge clk) C_data_out <= c_mem[C_index[2:0]];

  // result-side back-pressure, random when rand_mode is set
  always @(posedge clk) begin
    #1;
    bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // passive monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (A_wr_en) a_q.push_back({A_index, A_data_in});
    if (B_wr_en) b_q.push_back({B_index, B_data_in});
    if (tpu_in_valid) begin
      launch_cnt++;
      launch_cyc = cyc;
      launch_kmn = {tpu_K, tpu_M, tpu_N};
    end
    if (bus.out_valid && !prev_ov) rise_q.push_back(cyc);
    if (prev_stall) begin
      stall_seen++;
      if (!bus.out_valid || bus.out_data !== prev_data) stall_bad++;
    end
    if (bus.out_valid && bus.out_ready) begin
      out_q.push_back(bus.out_data);
      last_q.push_back(bus.out_last);
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
    prev_ov    = bus.out_valid;
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input int r, input int j);
    return {8'hC0, r[7:0], 8'h00, j[7:0]};
  endfunction

  task automatic check_idle_outs(input string tag);
    chk({tag, "_ctl"}, {bus.cmd_ready, bus.ld_ready, bus.out_valid, bus.out_last, A_wr_en,
                        B_wr_en, tpu_in_valid, done, err, tpu_K, tpu_M, tpu_N, C_index}, '0);
    chk({tag, "_dat"}, {bus.out_data, A_data_in, B_data_in, A_index, B_index}, '0);
  endtask

  task automatic send_cmd(input logic [7:0] k, input logic [7:0] m, input logic [7:0] n);
    bit ok;
    ok = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_K = k;
    bus.cmd_M = m;
    bus.cmd_N = n;
    for (int i = 0; i < 50; i++) begin
      if (bus.cmd_ready) begin
        ok = 1;
        tick();
        break;
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
    if (!ok) chk("cmd_accept", ok, 1);
  endtask

  task automatic send_beat(input logic [31:0] d);
    bit ok;
    ok = 0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    for (int i = 0; i < 50; i++) begin
      if (bus.ld_ready) begin
        ok = 1;
        tick();
        break;
      end
      tick();
    end
    bus.ld_valid = 1'b0;
    if (!ok) chk("beat_accept", ok, 1);
  endtask

  task automatic run_job(input logic [7:0] k, input logic [7:0] m, input logic [7:0] n,
                         input int na, input int nb, input int nrows,
                         input int busy_hi, input int exp_lat);
    int a0, b0, o0, r0, l0, d0;
    bit ok;
    logic [63:0] lastv;
    a0 = a_q.size(); b0 = b_q.size(); o0 = out_q.size();
    r0 = rise_q.size(); l0 = launch_cnt; d0 = done_cnt;
    send_cmd(k, m, n);
    // a competing command held during the load must be ignored
    bus.cmd_valid = 1'b1;
    bus.cmd_K = 8'hEE; bus.cmd_M = 8'hEE; bus.cmd_N = 8'hEE;
    for (int i = 0; i < na + nb; i++) begin
      send_beat(32'h11 * (i + 1));
      if (i == 0) tick();
    end
    bus.cmd_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (tpu_in_valid) begin ok = 1; break; end
      tick();
    end
    chk("launch_seen", ok, 1);
    if (busy_hi > 0) begin
      tick();
      tick();
      tpu_busy = 1'b1;
      repeat (busy_hi) tick();
      tpu_busy = 1'b0;
    end
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      if (done) begin ok = 1; break; end
      tick();
    end
    chk("done_seen", ok, 1);
    tick();
    chk("done_width", done, 0);
    chk("cmd_ready_after_done", bus.cmd_ready, 1);
    chk("a_count", a_q.size() - a0, na);
    for (int i = 0; i < na && a0 + i < a_q.size(); i++)
      chk("a_write", a_q[a0 + i], {16'(i), 32'(32'h11 * (i + 1))});
    chk("b_count", b_q.size() - b0, nb);
    for (int j = 0; j < nb && b0 + j < b_q.size(); j++)
      chk("b_write", b_q[b0 + j], {16'(j), 32'(32'h11 * (na + j + 1))});
    chk("launches", launch_cnt - l0, 1);
    chk("tpu_kmn", launch_kmn, {k, m, n});
    chk("drain_latency", (rise_q.size() > r0) ? rise_q[r0] - launch_cyc : -1, exp_lat);
    chk("word_count", out_q.size() - o0, nrows * 4);
    lastv = '0;
    for (int i = 0; i < nrows * 4 && o0 + i < out_q.size(); i++) begin
      chk("out_word", out_q[o0 + i], exp_word(i / 4, i % 4));
      lastv[i] = last_q[o0 + i];
    end
    chk("out_last", lastv, 64'd1 << (nrows * 4 - 1));
    chk("done_pulses", done_cnt - d0, 1);
    chk("stall_hold", stall_bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, b0, l0, d0, e0;
    bit ok;
    for (int r = 0; r < 8; r++)
      c_mem[r] = {exp_word(r, 0), exp_word(r, 1), exp_word(r, 2), exp_word(r, 3)};
    rst_n = 1'b0;
    tpu_busy = 1'b0;
    rand_mode = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_K = '0; bus.cmd_M = '0; bus.cmd_N = '0;
    bus.ld_valid = 1'b0;
    bus.ld_data = '0;
    repeat (3) tick();
    check_idle_outs("reset");
    rst_n = 1'b1;
    tick();
    chk("cmd_ready_post_reset", bus.cmd_ready, 1);

    // K=2,M=4,N=4: NA=2, NB=2, NC=4; busy high 10 cycles
    run_job(8'd2, 8'd4, 8'd4, 2, 2, 4, 10, 15);
    chk("first_word", out_q[0], 32'hC000_0000);

    // same job with random back-pressure on the result stream
    rand_mode = 1'b1;
    run_job(8'd2, 8'd4, 8'd4, 2, 2, 4, 10, 15);
    rand_mode = 1'b0;
    chk("stalls_seen", stall_seen > 0, 1);

    // M=0 is rejected; idle load beats are ignored
    a0 = a_q.size(); b0 = b_q.size(); l0 = launch_cnt; e0 = err_cnt;
    send_cmd(8'd2, 8'd0, 8'd4);
    chk("err_pulse", err, 1);
    chk("cmd_ready_err_cycle", bus.cmd_ready, 0);
    tick();
    chk("err_width", err, 0);
    chk("cmd_ready_after_err", bus.cmd_ready, 1);
    bus.ld_valid = 1'b1;
    bus.ld_data = 32'hBAD0_BAD0;
    repeat (4) tick();
    bus.ld_valid = 1'b0;
    chk("err_no_writes", (a_q.size() - a0) + (b_q.size() - b0), 0);
    chk("err_no_launch", launch_cnt - l0, 0);
    chk("err_count", err_cnt - e0, 1);

    // busy never rises: WAIT_LO forced 16 cycles after LAUNCH; M=5,N=1 -> 5 rows
    run_job(8'd1, 8'd5, 8'd1, 2, 1, 5, 0, 19);

    // reset in the middle of LOAD_B
    b0 = b_q.size(); l0 = launch_cnt;
    send_cmd(8'd2, 8'd4, 8'd4);
    send_beat(32'h11);
    send_beat(32'h22);
    send_beat(32'h33);
    rst_n = 1'b0;
    tick();
    check_idle_outs("rst_load_b");
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rst_load_b_bwrites", b_q.size() - b0, 1);
    chk("rst_load_b_launch", launch_cnt - l0, 0);
    chk("rst_load_b_ready", bus.cmd_ready, 1);

    // reset in the middle of DRAIN_OUT
    d0 = done_cnt;
    send_cmd(8'd2, 8'd4, 8'd4);
    for (int i = 0; i < 4; i++) send_beat(32'h11 * (i + 1));
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.out_valid) begin ok = 1; break; end
      tick();
    end
    chk("drain_reached", ok, 1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_idle_outs("rst_drain");
    rst_n = 1'b1;
    tick();
    chk("rst_drain_no_done", done_cnt - d0, 0);

    // a full job still completes after the aborted one
    run_job(8'd2, 8'd4, 8'd4, 2, 2, 4, 10, 15);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
